// File: rtl/mem_req_initiator_pkg.sv
// Shared definitions for the memory request initiator: opcodes, line width,
// FSM state encoding and requester identifiers.
package mem_req_initiator_pkg;

  localparam logic [3:0] MEM_LOAD_LINE  = 4'd4;
  localparam logic [3:0] MEM_STORE_LINE = 4'd7;
  localparam int         LINE_W         = 128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Which cache owns the transaction currently in flight.
  typedef enum logic {
    SRC_L1I = 1'b0,
    SRC_L1D = 1'b1
  } src_e;

endpackage

// File: rtl/mem_req_initiator_if.sv
// Bundle of the L1I/L1D request side and the memory request/response side.
//
// Handshake semantics: an L1 requester raises *_req_valid with stable
// addr/opcode/data and holds it until it sees the one-cycle *_req_ack pulse.
// mem_req_valid stays high with stable addr/opcode/store_data until
// mem_rsp_valid is sampled high on a rising edge; mem_rsp_valid is a one-cycle
// completion and is only meaningful while a request is outstanding.
// *_rsp_valid is a one-cycle completion pulse that carries rsp_load_data.
interface mem_req_initiator_if #(
  parameter int ADDR_W = 64
);
  import mem_req_initiator_pkg::*;

  logic              l1i_req_valid;
  logic [ADDR_W-1:0] l1i_req_addr;
  logic              l1i_req_ack;

  logic              l1d_req_valid;
  logic [ADDR_W-1:0] l1d_req_addr;
  logic [3:0]        l1d_req_opcode;
  logic [LINE_W-1:0] l1d_req_store_data;
  logic              l1d_req_ack;

  logic              l1i_rsp_valid;
  logic              l1d_rsp_valid;
  logic [LINE_W-1:0] rsp_load_data;

  logic              mem_req_valid;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [3:0]        mem_req_opcode;
  logic [LINE_W-1:0] mem_req_store_data;

  logic              mem_rsp_valid;
  logic [LINE_W-1:0] mem_rsp_load_data;

  // The initiator: masters the memory request, serves the L1 requesters.
  modport master (
    input  l1i_req_valid, l1i_req_addr,
    output l1i_req_ack,
    input  l1d_req_valid, l1d_req_addr, l1d_req_opcode, l1d_req_store_data,
    output l1d_req_ack,
    output l1i_rsp_valid, l1d_rsp_valid, rsp_load_data,
    output mem_req_valid, mem_req_addr, mem_req_opcode, mem_req_store_data,
    input  mem_rsp_valid, mem_rsp_load_data
  );

  // The environment: L1 requesters plus the memory responder.
  modport slave (
    output l1i_req_valid, l1i_req_addr,
    input  l1i_req_ack,
    output l1d_req_valid, l1d_req_addr, l1d_req_opcode, l1d_req_store_data,
    input  l1d_req_ack,
    input  l1i_rsp_valid, l1d_rsp_valid, rsp_load_data,
    input  mem_req_valid, mem_req_addr, mem_req_opcode, mem_req_store_data,
    output mem_rsp_valid, mem_rsp_load_data
  );

endinterface

// File: rtl/mem_req_initiator_rr_arb2.sv
// Two-way round-robin arbiter. On a tie the requester granted last loses.
// After reset index 0 counts as last granted, so index 1 wins the first tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       take_i,   // the grant is consumed this cycle
  output logic [1:0] gnt_o
);

  logic last_q, last_d;  // index granted most recently

  // One-hot grant and pointer update when the grant is taken.
  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = last_q ? 2'b01 : 2'b10;
    end
    last_d = last_q;
    if (take_i && (gnt_o != 2'b00)) begin
      last_d = gnt_o[1];
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (reset) last_q <= 1'b0;
    else       last_q <= last_d;
  end

endmodule

// File: rtl/mem_req_initiator.sv
// Memory request initiator: arbitrates L1I/L1D line requests, issues one
// memory request at a time, returns the response to the granted cache and
// flags a sticky timeout when memory is slow to answer.
//
// Timing: requests sampled in IDLE are acked in the next cycle (first ISSUE
// cycle); the response sampled in ISSUE moves to DONE; the completion pulse
// is registered out of DONE, so it appears in the cycle after DONE.
module mem_req_initiator
  import mem_req_initiator_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int ADDR_W         = 64
) (
  input  logic                clk,
  input  logic                reset,
  mem_req_initiator_if.master bus,
  output logic                busy,
  output logic                timeout,
  output state_e              dbg_state
);

  localparam int                CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(15);

  state_e            state_q, state_d;
  src_e              src_q, src_d;
  logic              l1i_ack_q, l1i_ack_d;
  logic              l1d_ack_q, l1d_ack_d;
  logic              l1i_rsp_q, l1i_rsp_d;
  logic              l1d_rsp_q, l1d_rsp_d;
  logic              mem_valid_q, mem_valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        opc_q, opc_d;
  logic [LINE_W-1:0] sdata_q, sdata_d;
  logic [LINE_W-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]  wait_q, wait_d;
  logic              busy_q, busy_d;
  logic              timeout_q, timeout_d;

  logic [1:0]        arb_gnt;  // [0] = L1I, [1] = L1D

  rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req_i  ({bus.l1d_req_valid, bus.l1i_req_valid}),
    .take_i (state_q == ST_IDLE),
    .gnt_o  (arb_gnt)
  );

  // Next-state and next-output computation for the request FSM.
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    l1i_ack_d   = 1'b0;
    l1d_ack_d   = 1'b0;
    l1i_rsp_d   = 1'b0;
    l1d_rsp_d   = 1'b0;
    mem_valid_d = mem_valid_q;
    addr_d      = addr_q;
    opc_d       = opc_q;
    sdata_d     = sdata_q;
    rdata_d     = rdata_q;
    wait_d      = wait_q;

    unique case (state_q)
      ST_IDLE: begin
        if (arb_gnt[1]) begin
          l1d_ack_d   = 1'b1;
          src_d       = SRC_L1D;
          addr_d      = bus.l1d_req_addr & LINE_MASK;
          opc_d       = bus.l1d_req_opcode;
          sdata_d     = bus.l1d_req_store_data;
          mem_valid_d = 1'b1;
          wait_d      = '0;
          state_d     = ST_ISSUE;
        end else if (arb_gnt[0]) begin
          // Instruction fills are always plain line loads.
          l1i_ack_d   = 1'b1;
          src_d       = SRC_L1I;
          addr_d      = bus.l1i_req_addr & LINE_MASK;
          opc_d       = MEM_LOAD_LINE;
          sdata_d     = '0;
          mem_valid_d = 1'b1;
          wait_d      = '0;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (bus.mem_rsp_valid) begin
          mem_valid_d = 1'b0;
          rdata_d     = (opc_q == MEM_STORE_LINE) ? '0 : bus.mem_rsp_load_data;
          state_d     = ST_DONE;
        end else if (wait_q != CNT_MAX) begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (src_q == SRC_L1D) l1d_rsp_d = 1'b1;
        else                  l1i_rsp_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d     = ST_IDLE;
        mem_valid_d = 1'b0;
      end
    endcase

    busy_d    = (state_d != ST_IDLE);
    // Timeout only raises the flag; the request keeps waiting for memory.
    timeout_d = timeout_q | (wait_d == CNT_MAX);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      src_q       <= SRC_L1I;
      l1i_ack_q   <= 1'b0;
      l1d_ack_q   <= 1'b0;
      l1i_rsp_q   <= 1'b0;
      l1d_rsp_q   <= 1'b0;
      mem_valid_q <= 1'b0;
      addr_q      <= '0;
      opc_q       <= '0;
      sdata_q     <= '0;
      rdata_q     <= '0;
      wait_q      <= '0;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      l1i_ack_q   <= l1i_ack_d;
      l1d_ack_q   <= l1d_ack_d;
      l1i_rsp_q   <= l1i_rsp_d;
      l1d_rsp_q   <= l1d_rsp_d;
      mem_valid_q <= mem_valid_d;
      addr_q      <= addr_d;
      opc_q       <= opc_d;
      sdata_q     <= sdata_d;
      rdata_q     <= rdata_d;
      wait_q      <= wait_d;
      busy_q      <= busy_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.l1i_req_ack        = l1i_ack_q;
  assign bus.l1d_req_ack        = l1d_ack_q;
  assign bus.l1i_rsp_valid      = l1i_rsp_q;
  assign bus.l1d_rsp_valid      = l1d_rsp_q;
  assign bus.rsp_load_data      = rdata_q;
  assign bus.mem_req_valid      = mem_valid_q;
  assign bus.mem_req_addr       = addr_q;
  assign bus.mem_req_opcode     = opc_q;
  assign bus.mem_req_store_data = sdata_q;
  assign busy                   = busy_q;
  assign timeout                = timeout_q;
  assign dbg_state              = state_q;

endmodule

// File: tb/tb_mem_req_initiator.sv
// Directed bench for mem_req_initiator: a table of single transactions
// (arbitration order, address alignment, opcode handling, response data)
// plus hand-written timeout and reset-abort sequences.
module tb_mem_req_initiator;
  import mem_req_initiator_pkg::*;

  localparam int ADDR_W = 64;
  localparam int TO_CYC = 8;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   reset;
  logic   busy;
  logic   timeout;
  state_e dbg_state;

  always #5 clk = ~clk;

  mem_req_initiator_if #(.ADDR_W(ADDR_W)) bus ();

  mem_req_initiator #(
    .TIMEOUT_CYCLES (TO_CYC),
    .ADDR_W         (ADDR_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .busy      (busy),
    .timeout   (timeout),
    .dbg_state (dbg_state)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- vector table ----------------
  typedef struct {
    logic              i_v;
    logic              d_v;
    logic [ADDR_W-1:0] i_addr;
    logic [ADDR_W-1:0] d_addr;
    logic [3:0]        d_opc;
    logic [127:0]      d_data;
    int                delay;      // cycles memory waits after the ack cycle
    logic [127:0]      rsp_data;
    logic              exp_d;      // 1: L1D expected to win
    logic [ADDR_W-1:0] exp_addr;
    logic [3:0]        exp_opc;
    logic [127:0]      exp_sdata;
    logic [127:0]      exp_rdata;
    logic              exp_to;
  } vec_t;

  vec_t vecs[8];

  // ---------------- driver / checker tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    bus.l1i_req_valid      = 1'b0;
    bus.l1i_req_addr       = '0;
    bus.l1d_req_valid      = 1'b0;
    bus.l1d_req_addr       = '0;
    bus.l1d_req_opcode     = '0;
    bus.l1d_req_store_data = '0;
    bus.mem_rsp_valid      = 1'b0;
    bus.mem_rsp_load_data  = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive_idle();
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".l1i_ack"},   128'(bus.l1i_req_ack),        '0);
    chk({tag, ".l1d_ack"},   128'(bus.l1d_req_ack),        '0);
    chk({tag, ".l1i_rsp"},   128'(bus.l1i_rsp_valid),      '0);
    chk({tag, ".l1d_rsp"},   128'(bus.l1d_rsp_valid),      '0);
    chk({tag, ".mem_valid"}, 128'(bus.mem_req_valid),      '0);
    chk({tag, ".mem_addr"},  128'(bus.mem_req_addr),       '0);
    chk({tag, ".mem_opc"},   128'(bus.mem_req_opcode),     '0);
    chk({tag, ".mem_sdata"}, bus.mem_req_store_data,       '0);
    chk({tag, ".rdata"},     bus.rsp_load_data,            '0);
    chk({tag, ".busy"},      128'(busy),                   '0);
    chk({tag, ".timeout"},   128'(timeout),                '0);
    chk({tag, ".state"},     128'(dbg_state),              128'(ST_IDLE));
  endtask

  task automatic chk_req(input string tag, input vec_t v);
    chk({tag, ".mem_valid"}, 128'(bus.mem_req_valid),  128'(1'b1));
    chk({tag, ".mem_addr"},  128'(bus.mem_req_addr),   128'(v.exp_addr));
    chk({tag, ".mem_opc"},   128'(bus.mem_req_opcode), 128'(v.exp_opc));
    chk({tag, ".mem_sdata"}, bus.mem_req_store_data,   v.exp_sdata);
    chk({tag, ".busy"},      128'(busy),               128'(1'b1));
  endtask

  // One full transaction from IDLE. Request presented before edge E1,
  // acked after E1, memory answers after `delay` more cycles, DONE follows,
  // then the completion pulse: three edges from request to pulse at delay 0.
  task automatic run_txn(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("v%0d", idx);
    bus.l1i_req_valid      = v.i_v;
    bus.l1i_req_addr       = v.i_addr;
    bus.l1d_req_valid      = v.d_v;
    bus.l1d_req_addr       = v.d_addr;
    bus.l1d_req_opcode     = v.d_opc;
    bus.l1d_req_store_data = v.d_data;
    step();
    chk({tag, ".l1d_ack"}, 128'(bus.l1d_req_ack), 128'(v.exp_d));
    chk({tag, ".l1i_ack"}, 128'(bus.l1i_req_ack), 128'(!v.exp_d));
    chk({tag, ".state_issue"}, 128'(dbg_state), 128'(ST_ISSUE));
    chk_req({tag, ".ack"}, v);
    bus.l1i_req_valid = 1'b0;
    bus.l1d_req_valid = 1'b0;
    for (int k = 0; k < v.delay; k++) begin
      step();
      chk({tag, ".ack_one_pulse"}, 128'({bus.l1i_req_ack, bus.l1d_req_ack}), '0);
      chk_req({tag, ".hold"}, v);
    end
    bus.mem_rsp_valid     = 1'b1;
    bus.mem_rsp_load_data = v.rsp_data;
    step();
    // Stray response in DONE with other data: must be ignored.
    bus.mem_rsp_load_data = ~v.rsp_data;
    chk({tag, ".done_mem_valid"}, 128'(bus.mem_req_valid), '0);
    chk({tag, ".state_done"}, 128'(dbg_state), 128'(ST_DONE));
    chk({tag, ".done_busy"}, 128'(busy), 128'(1'b1));
    chk({tag, ".done_no_rsp"}, 128'({bus.l1i_rsp_valid, bus.l1d_rsp_valid}), '0);
    step();
    bus.mem_rsp_valid = 1'b0;
    chk({tag, ".l1d_rsp"}, 128'(bus.l1d_rsp_valid), 128'(v.exp_d));
    chk({tag, ".l1i_rsp"}, 128'(bus.l1i_rsp_valid), 128'(!v.exp_d));
    chk({tag, ".rdata"}, bus.rsp_load_data, v.exp_rdata);
    chk({tag, ".idle_busy"}, 128'(busy), '0);
    chk({tag, ".state_idle"}, 128'(dbg_state), 128'(ST_IDLE));
    chk({tag, ".timeout"}, 128'(timeout), 128'(v.exp_to));
    step();
    chk({tag, ".rsp_one_pulse"}, 128'({bus.l1i_rsp_valid, bus.l1d_rsp_valid}), '0);
    chk({tag, ".rdata_hold"}, bus.rsp_load_data, v.exp_rdata);
  endtask

  // ---------------- scoreboard-free main sequence ----------------
  initial begin
    logic [127:0] line13;
    logic [127:0] beef;
    logic [127:0] a5;
    line13 = {4{32'h0000_0013}};
    beef   = {4{32'hDEAD_BEEF}};
    a5     = {16{8'hA5}};

    // L1I fill, responder one cycle later
    vecs[0] = '{1'b1, 1'b0, 64'h1004, 64'h0, 4'd0, '0, 1, line13,
                1'b0, 64'h1000, MEM_LOAD_LINE, '0, line13, 1'b0};
    // tie, last granted was L1I -> L1D
    vecs[1] = '{1'b1, 1'b1, 64'h500F, 64'h3008, MEM_LOAD_LINE, beef, 0,
                128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
                1'b1, 64'h3000, MEM_LOAD_LINE, beef,
                128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1'b0};
    // tie again -> L1I, store data forced to zero
    vecs[2] = '{1'b1, 1'b1, 64'h500F, 64'h3008, MEM_LOAD_LINE, beef, 0,
                {2{64'hCAFE_F00D_1234_5678}},
                1'b0, 64'h5000, MEM_LOAD_LINE, '0, {2{64'hCAFE_F00D_1234_5678}}, 1'b0};
    // tie -> L1D store, response data discarded
    vecs[3] = '{1'b1, 1'b1, 64'h6000, 64'h2000, MEM_STORE_LINE, a5, 2,
                {4{32'hFFFF_FFFF}},
                1'b1, 64'h2000, MEM_STORE_LINE, a5, '0, 1'b0};
    // L1D alone with an unlisted opcode: forwarded unchanged
    vecs[4] = '{1'b0, 1'b1, 64'h0, 64'h40FF, 4'd9, {8{16'h5A5A}}, 3,
                {4{32'h1122_3344}},
                1'b1, 64'h40F0, 4'd9, {8{16'h5A5A}}, {4{32'h1122_3344}}, 1'b0};
    // L1D alone again, all-ones address
    vecs[5] = '{1'b0, 1'b1, 64'h0, {ADDR_W{1'b1}}, MEM_LOAD_LINE, '0, 0,
                {4{32'h89AB_CDEF}},
                1'b1, 64'hFFFF_FFFF_FFFF_FFF0, MEM_LOAD_LINE, '0, {4{32'h89AB_CDEF}}, 1'b0};
    // tie after L1D -> L1I, address below one line
    vecs[6] = '{1'b1, 1'b1, 64'h7, 64'h8000, MEM_LOAD_LINE, beef, 1,
                {4{32'h0BAD_CAFE}},
                1'b0, 64'h0, MEM_LOAD_LINE, '0, {4{32'h0BAD_CAFE}}, 1'b0};
    // slow store: held 10 cycles, trips the sticky timeout
    vecs[7] = '{1'b0, 1'b1, 64'h0, 64'h2000, MEM_STORE_LINE, a5, 10,
                {4{32'h7777_7777}},
                1'b1, 64'h2000, MEM_STORE_LINE, a5, '0, 1'b1};

    reset = 1'b1;
    drive_idle();
    step();
    chk_all_zero("reset");
    step();
    reset = 1'b0;
    // stray response while idle changes nothing
    bus.mem_rsp_valid     = 1'b1;
    bus.mem_rsp_load_data = line13;
    step();
    bus.mem_rsp_valid = 1'b0;
    chk_all_zero("idle_stray");

    for (int i = 0; i < 8; i++) begin
      run_txn(i, vecs[i]);
    end

    // ---- timeout: memory silent, flag rises after 8 ISSUE cycles ----
    do_reset();
    bus.l1i_req_valid = 1'b1;
    bus.l1i_req_addr  = 64'h9008;
    step();
    chk("to.ack", 128'(bus.l1i_req_ack), 128'(1'b1));
    bus.l1i_req_valid = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step();
      chk($sformatf("to.early_%0d", k), 128'(timeout), '0);
    end
    step();
    chk("to.raised", 128'(timeout), 128'(1'b1));
    chk("to.still_valid", 128'(bus.mem_req_valid), 128'(1'b1));
    chk("to.addr", 128'(bus.mem_req_addr), 128'(64'h9000));
    for (int k = 0; k < 4; k++) step();
    chk("to.sat_valid", 128'(bus.mem_req_valid), 128'(1'b1));
    bus.mem_rsp_valid     = 1'b1;
    bus.mem_rsp_load_data = {4{32'h1357_9BDF}};
    step();
    bus.mem_rsp_valid = 1'b0;
    step();
    chk("to.late_rsp", 128'(bus.l1i_rsp_valid), 128'(1'b1));
    chk("to.late_data", bus.rsp_load_data, {4{32'h1357_9BDF}});
    chk("to.sticky", 128'(timeout), 128'(1'b1));
    step();
    chk("to.sticky_idle", 128'(timeout), 128'(1'b1));

    // ---- reset during ISSUE drops the request ----
    do_reset();
    chk("rst.to_cleared", 128'(timeout), '0);
    bus.l1d_req_valid      = 1'b1;
    bus.l1d_req_addr       = 64'hABC0;
    bus.l1d_req_opcode     = MEM_LOAD_LINE;
    bus.l1d_req_store_data = beef;
    step();
    chk("rst.ack", 128'(bus.l1d_req_ack), 128'(1'b1));
    bus.l1d_req_valid = 1'b0;
    step();
    chk("rst.in_issue", 128'(dbg_state), 128'(ST_ISSUE));
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_all_zero("rst.mid_issue");
    bus.mem_rsp_valid     = 1'b1;
    bus.mem_rsp_load_data = line13;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("rst.stray_%0d", k), 128'({bus.l1i_rsp_valid, bus.l1d_rsp_valid}), '0);
    end
    bus.mem_rsp_valid = 1'b0;
    step();
    chk_all_zero("rst.after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_req_initiator.md
MEM_REQ_INITIATOR -- requirements
Module: mem_req_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning cycles waiting on mem_rsp_valid before timeout is flagged.
REQ-002 SHALL have parameter ADDR_W, default 64, meaning request address width.
REQ-003 SHALL have one clock and a synchronous active-high reset: clk  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-004 SHALL have port l1i_req_valid  in  1  L1I line-fill request, held until l1i_req_ack.
REQ-005 SHALL have port l1i_req_addr  in  ADDR_W  L1I fill address.
REQ-006 SHALL have port l1i_req_ack  out  1  one-cycle pulse: L1I request accepted.
REQ-007 SHALL have port l1d_req_valid  in  1  L1D request, held until l1d_req_ack.
REQ-008 SHALL have port l1d_req_addr  in  ADDR_W  L1D address.
REQ-009 SHALL have port l1d_req_opcode  in  4  4 = line load, 7 = line store.
REQ-010 SHALL have port l1d_req_store_data  in  128  L1D store line.
REQ-011 SHALL have port l1d_req_ack  out  1  one-cycle pulse: L1D request accepted.
REQ-012 SHALL have port l1i_rsp_valid / l1d_rsp_valid  out  1 each  one-cycle completion pulse to requester.
REQ-013 SHALL have port rsp_load_data  out  128  registered line returned with either rsp_valid.
REQ-014 SHALL have ports mem_req_valid  out  1; mem_req_addr  out  ADDR_W; mem_req_opcode  out  4; mem_req_store_data  out  128: memory request.
REQ-015 SHALL have ports mem_rsp_valid  in  1; mem_rsp_load_data  in  128: memory response.
REQ-016 SHALL have ports busy  out  1 and timeout  out  1 (sticky).

Function
REQ-017 SHALL use FSM states IDLE, ISSUE, DONE.
REQ-018 IDLE: if any requester valid, SHALL pick one by round-robin (last-granted loses ties), pulse its ack, latch addr/opcode/data, go ISSUE next cycle.
REQ-019 L1I requests SHALL always be issued with opcode 4 and mem_req_store_data zero.
REQ-020 mem_req_addr SHALL be the latched address with bits [3:0] forced to zero.
REQ-021 ISSUE: mem_req_valid SHALL be 1 with addr/opcode/store_data stable until mem_rsp_valid is sampled 1.
REQ-022 On mem_rsp_valid in ISSUE, SHALL deassert mem_req_valid the next cycle, register mem_rsp_load_data into rsp_load_data (store: zero), go DONE.
REQ-023 DONE: SHALL pulse the granted requester's rsp_valid for exactly one cycle, then return to IDLE.
REQ-024 Minimum latency acceptance-to-rsp_valid SHALL be 3 cycles with a same-cycle-ack responder; at most one request outstanding.
REQ-025 mem_rsp_valid outside ISSUE SHALL be ignored and not change any output.
REQ-026 Wait counter SHALL clear on entering ISSUE, increment each ISSUE cycle, saturate at TIMEOUT_CYCLES; reaching it SHALL set timeout (sticky until reset); the request SHALL remain pending.
REQ-027 busy SHALL be 1 in ISSUE and DONE, 0 in IDLE.
REQ-028 Opcodes other than 4 or 7 from L1D SHALL be forwarded unchanged.

Reset
REQ-029 Reset SHALL force IDLE; all acks, rsp_valids, mem_req_valid, busy, timeout to 0; mem_req_addr, opcode, store_data, rsp_load_data to 0; round-robin pointer to favour L1D.
REQ-030 Reset mid-ISSUE SHALL drop the request with no rsp_valid pulse; responses arriving after reset SHALL be ignored.

Structure
REQ-031 Opcode constants (MEM_LOAD_LINE=4, MEM_STORE_LINE=7) and the state enum SHALL live in the shared core package.
REQ-032 Round-robin 2-way arbiter SHALL be a sub-module named rr_arb2; everything else flat.

Verification
REQ-033 L1I fill addr 0x1004, responder acks next cycle with 4x 0x00000013 -> mem_req_addr 0x1000, opcode 4, l1i_rsp_valid one pulse, rsp_load_data = 0x00000013 repeated 4 times.
REQ-034 Simultaneous L1I and L1D valid after reset -> L1D granted first, L1I second; repeat -> alternates.
REQ-035 L1D store opcode 7 addr 0x2000 data 0xA5 pattern, responder delays 10 cycles -> request held stable 10+ cycles, l1d_rsp_valid pulse, rsp_load_data 0.
REQ-036 TIMEOUT_CYCLES=8, responder silent -> timeout rises after 8 ISSUE cycles, mem_req_valid stays 1; late response still completes.
REQ-037 reset asserted during ISSUE -> next cycle all outputs 0, IDLE; stray mem_rsp_valid afterward produces no rsp_valid.
